// File: rtl/countdown_scan_display.sv
// -----------------------------------------------------------------------------
// countdown_scan_display
//
// Two-digit multiplexed 7-segment driver for a traffic-light countdown.
// A captured value (0..31) is split into tens and units. They are shown
// alternately on a units and a tens digit, with a one-cycle blank gap between
// digits to avoid ghosting. The tens digit is blanked when it is zero. While
// the yellow phase is active, the whole display blinks with a half-period of
// pBLINK_FRAMES full scan frames.
//
// Ports
//   clk      in   single clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   global enable; when low every register holds
//   number   in   countdown value to display
//   load     in   capture strobe for number (qualified by en)
//   yellow   in   yellow phase active, enables blinking
//   seg      out  registered active-high segments, bit0=a .. bit6=g, bit7=dp
//   dig_sel  out  registered one-hot digit enable, bit0=units, bit1=tens
// -----------------------------------------------------------------------------
module countdown_scan_display #(
    parameter int pNUMBER_WIDTH = 5,
    parameter int pLED_WIDTH    = 8,
    parameter int pSCAN_DIV     = 49,
    parameter int pBLINK_FRAMES = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [pNUMBER_WIDTH-1:0] number,
    input  logic                     load,
    input  logic                     yellow,
    output logic [pLED_WIDTH-1:0]    seg,
    output logic [1:0]               dig_sel
);

    localparam int SCAN_W  = (pSCAN_DIV > 0) ? $clog2(pSCAN_DIV + 1) : 1;
    localparam int FRAME_W = (pBLINK_FRAMES > 1) ? $clog2(pBLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(pSCAN_DIV);
    localparam logic [FRAME_W-1:0] FRAME_MAX = FRAME_W'(pBLINK_FRAMES - 1);

    localparam logic [1:0] S_UNITS = 2'd0;
    localparam logic [1:0] S_GAP_U = 2'd1;
    localparam logic [1:0] S_TENS  = 2'd2;
    localparam logic [1:0] S_GAP_T = 2'd3;

    // Digit to segment pattern; anything outside 0..9 stays dark.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        logic [7:0] pattern;
        case (digit)
            4'd0:    pattern = 8'h3F;
            4'd1:    pattern = 8'h06;
            4'd2:    pattern = 8'h5B;
            4'd3:    pattern = 8'h4F;
            4'd4:    pattern = 8'h66;
            4'd5:    pattern = 8'h6D;
            4'd6:    pattern = 8'h7D;
            4'd7:    pattern = 8'h07;
            4'd8:    pattern = 8'h7F;
            4'd9:    pattern = 8'h6F;
            default: pattern = 8'h00;
        endcase
        return pattern;
    endfunction

    logic [1:0]               r_state;
    logic [SCAN_W-1:0]        r_scan;
    logic [pNUMBER_WIDTH-1:0] r_num;
    logic [FRAME_W-1:0]       r_frame;
    logic                     r_blink_ph;
    logic [pLED_WIDTH-1:0]    r_seg;
    logic [1:0]               r_dig_sel;

    logic [1:0]               w_state_next;
    logic [SCAN_W-1:0]        w_scan_next;
    logic                     w_frame_tick;
    logic [pNUMBER_WIDTH-1:0] w_num_next;
    logic [FRAME_W-1:0]       w_frame_next;
    logic                     w_blink_next;
    logic [31:0]              w_num_ext;
    logic [3:0]               w_tens;
    logic [3:0]               w_units;
    logic [pLED_WIDTH-1:0]    w_seg_next;
    logic [1:0]               w_dig_next;

    // The outputs are decoded from the value being captured this edge, so a
    // load that coincides with entering a digit is shown immediately.
    assign w_num_next = load ? number : r_num;
    assign w_num_ext  = 32'(w_num_next);
    assign w_tens     = 4'(w_num_ext / 32'd10);
    assign w_units    = 4'(w_num_ext % 32'd10);

    // Scan FSM next state and dwell counter.
    always_comb begin
        w_state_next = r_state;
        w_scan_next  = r_scan;
        w_frame_tick = 1'b0;
        case (r_state)
            S_UNITS: begin
                if (r_scan == SCAN_MAX) begin
                    w_state_next = S_GAP_U;
                    w_scan_next  = {SCAN_W{1'b0}};
                end else begin
                    w_scan_next  = r_scan + SCAN_W'(1);
                end
            end
            S_GAP_U: begin
                w_state_next = S_TENS;
                w_scan_next  = {SCAN_W{1'b0}};
            end
            S_TENS: begin
                if (r_scan == SCAN_MAX) begin
                    w_state_next = S_GAP_T;
                    w_scan_next  = {SCAN_W{1'b0}};
                end else begin
                    w_scan_next  = r_scan + SCAN_W'(1);
                end
            end
            S_GAP_T: begin
                // Closing a frame: this is the event the blink timer counts.
                w_state_next = S_UNITS;
                w_scan_next  = {SCAN_W{1'b0}};
                w_frame_tick = 1'b1;
            end
            default: begin
                w_state_next = S_GAP_T;
                w_scan_next  = {SCAN_W{1'b0}};
            end
        endcase
    end

    // Blink timer: counts frames while yellow, toggles the blink phase.
    always_comb begin
        w_frame_next = r_frame;
        w_blink_next = r_blink_ph;
        if (!yellow) begin
            w_frame_next = {FRAME_W{1'b0}};
            w_blink_next = 1'b0;
        end else if (w_frame_tick) begin
            if (r_frame == FRAME_MAX) begin
                w_frame_next = {FRAME_W{1'b0}};
                w_blink_next = ~r_blink_ph;
            end else begin
                w_frame_next = r_frame + FRAME_W'(1);
                w_blink_next = r_blink_ph;
            end
        end else begin
            w_frame_next = r_frame;
            w_blink_next = r_blink_ph;
        end
    end

    // Output decode from the next state, with leading-zero and blink blanking.
    always_comb begin
        w_seg_next = {pLED_WIDTH{1'b0}};
        w_dig_next = 2'b00;
        case (w_state_next)
            S_UNITS: begin
                w_dig_next = 2'b01;
                w_seg_next = pLED_WIDTH'(seg_encode(w_units));
            end
            S_TENS: begin
                w_dig_next = 2'b10;
                if (w_tens == 4'd0) begin
                    w_seg_next = {pLED_WIDTH{1'b0}};
                end else begin
                    w_seg_next = pLED_WIDTH'(seg_encode(w_tens));
                end
            end
            default: begin
                w_dig_next = 2'b00;
                w_seg_next = {pLED_WIDTH{1'b0}};
            end
        endcase
        if (yellow && w_blink_next) begin
            w_seg_next = {pLED_WIDTH{1'b0}};
        end else begin
            w_seg_next = w_seg_next;
        end
    end

    // State, captured value, blink timer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_GAP_T;
            r_scan     <= {SCAN_W{1'b0}};
            r_num      <= {pNUMBER_WIDTH{1'b0}};
            r_frame    <= {FRAME_W{1'b0}};
            r_blink_ph <= 1'b0;
            r_seg      <= {pLED_WIDTH{1'b0}};
            r_dig_sel  <= 2'b00;
        end else if (en) begin
            r_state    <= w_state_next;
            r_scan     <= w_scan_next;
            r_num      <= w_num_next;
            r_frame    <= w_frame_next;
            r_blink_ph <= w_blink_next;
            r_seg      <= w_seg_next;
            r_dig_sel  <= w_dig_next;
        end else begin
            r_state    <= r_state;
            r_scan     <= r_scan;
            r_num      <= r_num;
            r_frame    <= r_frame;
            r_blink_ph <= r_blink_ph;
            r_seg      <= r_seg;
            r_dig_sel  <= r_dig_sel;
        end
    end

    assign seg     = r_seg;
    assign dig_sel = r_dig_sel;

endmodule
